rr_arbiter_16: RTL and testbench
================================

# rr_arbiter_16

Round-robin arbiter that shares one 32-bit data path among 16 requesters by driving the select of the 16:1 32-bit data mux (mux_16to1_32bits). It grants one requester at a time for a burst of beats and holds the grant until that requester signals its last beat, drops its request, or hits the hold limit. A downstream valid/ready handshake paces the beats. It sits between the requesters and the shared consumer, such as a bus or memory port, in the miniRV datapath.

## Interface
- HOLD_MAX, default 16: maximum accepted beats per grant. Legal range is 1..256.
- clk  in  1  system clock. All state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  16  per-requester request. Bit i means requester i has data on mux input i.
- last  in  16  per-requester last-beat flag. It is sampled only for the current owner.
- out_ready  in  1  the downstream consumer accepts the current beat.
- gnt  out  16  one-hot grant. It is all-zero when idle.
- sel  out  4  mux select, equal to the owner index. It is 0 when idle.
- busy  out  1  a grant is active.
- out_valid  out  1  the beat on the mux output is valid.
- out_last  out  1  the current beat is the final beat of this grant.

## Operation
- Two states, IDLE and BUSY. Registered state: `ptr[3:0]`, `owner[3:0]`, `cnt`, where `cnt` is `$clog2(HOLD_MAX+1)` bits wide.
- Reset values: state IDLE, ptr=0, owner=0, cnt=0. Outputs are gnt=0, sel=0, busy=0, out_valid=0, out_last=0.
- IDLE behaviour:
  - If req≠0, pick the first set bit scanning ptr, ptr+1, …, 15, 0, …, ptr-1, wrapping mod 16.
  - Set owner to that index, cnt=0, and go to BUSY.
  - If req=0, stay in IDLE.
- BUSY outputs:
  - gnt = 1<<owner, sel = owner, busy = 1.
  - out_valid = req[owner].
  - out_last = out_valid & (last[owner] | cnt==HOLD_MAX-1).
- Beat accepted: a beat is accepted when out_valid & out_ready. On acceptance, cnt increments.
- Release:
  - Conditions: (a) an accepted beat with out_last=1, or (b) req[owner]=0 in BUSY (abort).
  - On release the next state is IDLE, ptr = owner+1 mod 16 (15 wraps to 0), and cnt=0.
- Bubble: there is one idle bubble cycle between grants, because re-arbitration happens only in IDLE.
- Backpressure: out_ready=0 holds cnt and the grant. A pending last beat is not released until it is accepted.
- Non-owners: req and last bits of non-owners are ignored while BUSY. A new request arriving during BUSY waits for IDLE.
- Reset mid-burst: asserting rst returns to the reset values at the next edge regardless of state. No partial release bookkeeping is kept; ptr becomes 0.

## Timing
- Grant latency: req sampled in IDLE on edge N gives gnt, sel and busy valid after edge N (cycle N+1). Minimum latency is 1 cycle.
- gnt, sel and busy are registered and glitch-free.
- out_valid and out_last are combinational from req and last through the registered owner.
- The mux data path is combinational. The consumer captures mux_out on the edge where out_valid & out_ready.
- Release edge: the beat accepted with out_last, or the abort, occurs on edge M. gnt becomes 0 after M. The next owner's gnt appears after M+1.
- Throughput: with constant requests and 1-beat bursts, one grant every 2 cycles.

## Structure
- Package `arb_pkg`:
  - `NREQ=16` and `IDX_W=4`.
  - State enum `{ARB_IDLE, ARB_BUSY}`.
- Sub-module `rr_pick16`, combinational:
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: idx[3:0], any.
  - Implementation: rotate right by ptr, find first set, add ptr mod 16.
- Top-level integration instantiates rr_arbiter_16 next to the mux and connects sel to the mux select.

## Test plan
- Reset: hold rst for 2 cycles with req=0xFFFF -> gnt=0, sel=0, busy=0, out_valid=0, out_last=0. After release, gnt=0x0001 one cycle later.
- Single burst: req=0x0008, out_ready=1, last[3] high on the 2nd beat -> gnt=0x0008 and sel=3 for exactly 2 cycles, out_last=1 on the 2nd, gnt=0 next cycle, ptr=4.
- Rotation and wrap: req=0xFFFF constant, last=0xFFFF, out_ready=1 -> sel sequence 0,1,…,15,0 with one bubble between grants, i.e. a grant every 2 cycles.
- Backpressure: owner 5 presenting its last beat, out_ready low for 3 cycles -> gnt=0x0020, cnt and out_last=1 are held. Release happens only after out_ready rises.
- Hold limit with HOLD_MAX=4: req=0x0003, last=0, out_ready=1 -> owner 0 gets 4 beats, out_last=1 on the 4th, then one bubble, then gnt=0x0002.
- Abort and reset: owner 7 drops req[7] mid-burst -> gnt=0 next cycle, then owner 8 or later per ptr. Asserting rst while BUSY -> all outputs 0 next edge and ptr=0.

Source files
------------

// File: rtl/rr_arbiter_16_pkg.sv
// Shared constants and types for the 16-way round-robin arbiter.
package arb_pkg;

   localparam int NREQ  = 16;
   localparam int IDX_W = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // One-hot decode of a requester index.
   function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter_16_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick16
   import arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [NREQ-1:0]  rot;
   logic [IDX_W-1:0] first;

   // Rotate right by ptr so the highest-priority requester lands on bit 0,
   // take the lowest set bit, then undo the rotation (4-bit add wraps mod 16).
   always_comb begin
      rot   = '0;
      first = '0;
      for (int i = 0; i < NREQ; i++) begin
         rot[i] = req[IDX_W'(i) + ptr];
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) first = IDX_W'(i);
      end
      idx = first + ptr;
      any = |req;
   end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter driving the select of a 16:1 data mux, with burst hold,
// last-beat / hold-limit / abort release and one idle bubble between grants.
//
//   state    | meaning
//   ARB_IDLE | no grant; re-arbitrate from ptr when any request is present
//   ARB_BUSY | owner holds the mux until last beat, hold limit or abort
module rr_arbiter_16
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  last,
   input  logic             out_ready,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] sel,
   output logic             busy,
   output logic             out_valid,
   output logic             out_last
);

   localparam int CNT_W = $clog2(HOLD_MAX + 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q,   ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [NREQ-1:0]  gnt_q,   gnt_d;
   logic [IDX_W-1:0] sel_q,   sel_d;
   logic             busy_q,  busy_d;

   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             hold_end;
   logic             beat_acc;

   rr_pick16 u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Beat handshake is combinational through the registered owner.
   assign hold_end  = (cnt_q == CNT_W'(HOLD_MAX - 1));
   assign out_valid = (state_q == ARB_BUSY) & req[owner_q];
   assign out_last  = out_valid & (last[owner_q] | hold_end);
   assign beat_acc  = out_valid & out_ready;

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = busy_q;

   // Next-state: grant from IDLE, count beats and release from BUSY.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_BUSY;
               owner_d = pick_idx;
               cnt_d   = '0;
               gnt_d   = idx_to_onehot(pick_idx);
               sel_d   = pick_idx;
               busy_d  = 1'b1;
            end
         end
         ARB_BUSY: begin
            // Abort (owner dropped req) or accepted final beat both release.
            if (!req[owner_q] || (beat_acc && out_last)) begin
               state_d = ARB_IDLE;
               ptr_d   = owner_q + IDX_W'(1);
               cnt_d   = '0;
               gnt_d   = '0;
               sel_d   = '0;
               busy_d  = 1'b0;
            end else if (beat_acc) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16: directed scenarios with literal expectations plus a
// cycle-by-cycle comparison against a behavioural arbitration model.
module tb_rr_arbiter_16;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic [15:0] last;
   logic        out_ready;
   logic [15:0] gnt;
   logic [3:0]  sel;
   logic        busy;
   logic        out_valid;
   logic        out_last;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // behavioural model state
   bit m_busy  = 1'b0;
   int m_owner = 0;
   int m_ptr   = 0;
   int m_beats = 0;

   rr_arbiter_16 #(.HOLD_MAX(HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .last      (last),
      .out_ready (out_ready),
      .gnt       (gnt),
      .sel       (sel),
      .busy      (busy),
      .out_valid (out_valid),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Model: arbitration and release rules applied once per rising edge.
   always @(posedge clk) begin
      bit rel;
      rel = 1'b0;
      if (rst) begin
         m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_beats = 0;
      end else if (!m_busy) begin
         for (int k = 0; k < 16; k++) begin
            int j;
            j = (m_ptr + k) % 16;
            if (req[j] && !m_busy) begin
               m_busy = 1'b1; m_owner = j; m_beats = 0;
            end
         end
      end else begin
         if (!req[m_owner]) rel = 1'b1;
         else if (out_ready) begin
            if (last[m_owner] || m_beats == HOLD - 1) rel = 1'b1;
            else m_beats++;
         end
         if (rel) begin
            m_busy = 1'b0; m_ptr = (m_owner + 1) % 16; m_beats = 0;
         end
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [15:0] e_gnt;
         logic        e_val;
         logic        e_last;
         e_gnt  = m_busy ? (16'h0001 << m_owner) : 16'h0000;
         e_val  = m_busy && req[m_owner];
         e_last = e_val && (last[m_owner] || m_beats == HOLD - 1);
         check("model_gnt",  32'(gnt), 32'(e_gnt));
         check("model_sel",  32'(sel), m_busy ? 32'(m_owner) : 32'd0);
         check("model_busy", 32'(busy), 32'(m_busy));
         check("model_valid", 32'(out_valid), 32'(e_val));
         check("model_last", 32'(out_last), 32'(e_last));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 16'hFFFF; last = 16'h0000; out_ready = 1'b1;
      tick();
      tick();
      cmp_en = 1'b1;
      @(negedge clk);
      check("rst_gnt",  32'(gnt), 32'h0);
      check("rst_sel",  32'(sel), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_last", 32'(out_last), 32'h0);
      tick();
      rst = 1'b0; req = 16'h0000;
   endtask

   initial begin
      rst = 1'b1; req = 16'h0000; last = 16'h0000; out_ready = 1'b0;

      // reset with all requests asserted, then first grant to requester 0
      do_reset();
      req = 16'hFFFF; out_ready = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 32'(gnt), 32'h0);
      tick();
      @(negedge clk);
      check("first_gnt", 32'(gnt), 32'h0001);

      // single 2-beat burst from requester 3, then ptr=4 visible in next pick
      do_reset();
      req = 16'h0008; last = 16'h0000; out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("burst_gnt1", 32'(gnt), 32'h0008);
      check("burst_sel1", 32'(sel), 32'd3);
      check("burst_last1", 32'(out_last), 32'd0);
      tick();
      last = 16'h0008;
      @(negedge clk);
      check("burst_gnt2", 32'(gnt), 32'h0008);
      check("burst_last2", 32'(out_last), 32'd1);
      tick();
      req = 16'hFFFF; last = 16'h0000;
      @(negedge clk);
      check("burst_rel", 32'(gnt), 32'h0);
      tick();
      @(negedge clk);
      check("burst_ptr4", 32'(gnt), 32'h0010);

      // rotation with 1-beat bursts: sel 0..15,0 with a bubble between
      do_reset();
      req = 16'hFFFF; last = 16'hFFFF; out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         @(negedge clk);
         check("rot_sel",  32'(sel), 32'(k % 16));
         check("rot_busy", 32'(busy), 32'd1);
         tick();
         @(negedge clk);
         check("rot_bubble", 32'(busy), 32'd0);
      end

      // backpressure on owner 5's last beat
      do_reset();
      req = 16'h0020; last = 16'h0020; out_ready = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_gnt",  32'(gnt), 32'h0020);
         check("bp_last", 32'(out_last), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_held", 32'(gnt), 32'h0020);
      tick();
      @(negedge clk);
      check("bp_rel", 32'(gnt), 32'h0);

      // hold limit: owner 0 gets HOLD beats, then bubble, then owner 1
      do_reset();
      req = 16'h0003; last = 16'h0000; out_ready = 1'b1;
      tick();
      for (int b = 0; b < HOLD; b++) begin
         @(negedge clk);
         check("hold_gnt",  32'(gnt), 32'h0001);
         check("hold_last", 32'(out_last), (b == HOLD - 1) ? 32'd1 : 32'd0);
         tick();
      end
      @(negedge clk);
      check("hold_bubble", 32'(gnt), 32'h0);
      tick();
      @(negedge clk);
      check("hold_next", 32'(gnt), 32'h0002);

      // abort by owner 7, then owner 8 from ptr=8
      do_reset();
      req = 16'h0180; last = 16'h0000; out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("abort_gnt7", 32'(gnt), 32'h0080);
      tick();
      req = 16'h0100;
      @(negedge clk);
      check("abort_valid", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      check("abort_rel", 32'(gnt), 32'h0);
      tick();
      @(negedge clk);
      check("abort_gnt8", 32'(gnt), 32'h0100);

      // reset while busy: outputs clear and ptr returns to 0 (picks 7 not 8)
      req = 16'h0180; rst = 1'b1;
      tick();
      @(negedge clk);
      check("midrst_gnt",  32'(gnt), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      tick();
      @(negedge clk);
      check("midrst_ptr0", 32'(gnt), 32'h0080);

      // pseudo-random traffic, model-checked every cycle
      for (int c = 0; c < 400; c++) begin
         tick();
         req       = 16'($urandom());
         last      = 16'($urandom()) & 16'($urandom());
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 63) == 0);
      end
      tick();
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
